// File: rtl/buf512_reader_pkg.sv
// Shared constants for the 512x9 line-buffer reader: address/word widths and
// the field layout of a stored word (EOP flag above the payload byte).
package buf512_reader_pkg;
  localparam int unsigned AW_DEF    = 9;
  localparam int unsigned DW_DEF    = 9;
  localparam int unsigned EOP_BIT   = 8;
  localparam int unsigned PAYLOAD_W = 8;
endpackage

// File: rtl/buf512_reader_skid2.sv
// Two-entry valid/ready FIFO holding words returned by the buffer read port.
// The head entry is always in head_q so the output is a plain register.
module buf512_reader_skid2 #(
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic [1:0]    cnt_q;
  logic          push;
  logic          pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign count     = cnt_q;
  assign push      = in_valid;
  assign pop       = out_valid & out_ready;

  // The caller's credit scheme guarantees push never lands on a full FIFO without a pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= in_data;
          else               tail_q <= in_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= in_data;
          end else begin
            head_q <= in_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/buf512_reader.sv
// Read-side controller for a 512x9 line buffer: fetches committed words,
// buffers the 1-cycle RAM return in a 2-entry skid and streams them on valid/ready.
module buf512_reader
  import buf512_reader_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] wr_ptr,
  input  logic          flush,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_ptr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic          empty,
  output logic [7:0]    pkt_count
);
  logic [AW-1:0] rd_ptr_q;
  logic          inflight_q;
  logic [7:0]    pkt_q;
  logic [1:0]    skid_cnt;
  logic [DW-1:0] head;
  logic          avail;
  logic          accept;
  logic          fetch;
  logic [1:0]    credit_used;

  assign rd_ptr  = rd_ptr_q;
  assign rd_addr = rd_ptr_q;
  assign avail   = (rd_ptr_q != wr_ptr);
  assign accept  = out_valid & out_ready;

  // A word leaving the skid this cycle frees its slot now, which keeps 1 word/cycle
  // sustained; skid + in-flight can never exceed the two skid entries.
  always_comb begin
    credit_used = (skid_cnt + {1'b0, inflight_q}) - {1'b0, accept};
    fetch       = avail && (credit_used < 2'd2) && !flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      pkt_q      <= '0;
    end else begin
      inflight_q <= fetch;
      if (flush)      rd_ptr_q <= wr_ptr;
      else if (fetch) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (!flush && accept && out_last) pkt_q <= pkt_q + 8'd1;
    end
  end

  buf512_reader_skid2 #(.DW(DW)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (flush),
    .in_valid  (inflight_q),
    .in_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready & ~flush),
    .out_data  (head),
    .count     (skid_cnt)
  );

  assign out_data  = head[PAYLOAD_W-1:0];
  assign out_last  = head[EOP_BIT];
  assign empty     = !avail && !inflight_q && (skid_cnt == 2'd0);
  assign pkt_count = pkt_q;
endmodule

// File: tb/tb_buf512_reader.sv
// Bench for buf512_reader: models the 512x9 RAM and writer, keeps an in-order
// queue of committed words and checks every accepted word against it.
module tb_buf512_reader;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [8:0] wr_ptr;
  logic [8:0] rd_addr;
  logic [8:0] rd_ptr;
  logic [8:0] rd_data;
  logic       out_valid;
  logic       out_last;
  logic       empty;
  logic [7:0] out_data;
  logic [7:0] pkt_count;

  logic [8:0] mem [512];
  logic       wr_en = 1'b0;
  logic [8:0] wr_word = '0;
  logic       wr_load = 1'b0;
  logic [8:0] wr_load_val = '0;

  int         nvec = 0;
  int         nfail = 0;
  logic [8:0] exp_q [$];
  int         exp_pkt = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     wr_ptr <= '0;
    else if (wr_load) wr_ptr <= wr_load_val;
    else if (wr_en)   wr_ptr <= wr_ptr + 9'd1;
  end

  always @(posedge clk) begin
    if (wr_en && !wr_load) mem[wr_ptr] <= wr_word;
    rd_data <= mem[rd_addr];
  end

  buf512_reader #(.AW(9), .DW(9)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_ptr    (wr_ptr),
    .flush     (flush),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ptr    (rd_ptr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .empty     (empty),
    .pkt_count (pkt_count)
  );

  // One cycle of stimulus: writer commits w unless full; reports whether the
  // consumer takes a word at the coming edge and what the DUT presents.
  task automatic drive_cycle(input bit we, input logic [8:0] w, input bit rdy,
                             output bit wrote, output bit acc, output logic [8:0] got);
    @(negedge clk);
    flush   = 1'b0;
    wr_load = 1'b0;
    if (we && ((wr_ptr + 9'd1) != rd_ptr)) begin
      wr_en   = 1'b1;
      wr_word = w;
      exp_q.push_back(w);
      wrote   = 1'b1;
    end else begin
      wr_en = 1'b0;
      wrote = 1'b0;
    end
    out_ready = rdy;
    acc = (out_valid === 1'b1) && rdy;
    got = {out_last, out_data};
  endtask

  task automatic test_reset();
    #1;
    nvec += 5;
    if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    if (rd_ptr !== 9'd0) begin nfail++; $display("FAIL reset_rd_ptr got=%0d exp=0", rd_ptr); end
    if (empty !== 1'b1) begin nfail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (pkt_count !== 8'd0) begin nfail++; $display("FAIL reset_pkt got=%0d exp=0", pkt_count); end
    if ({out_last, out_data} !== 9'h000) begin nfail++; $display("FAIL reset_data got=%h exp=000", {out_last, out_data}); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [8:0] words [3] = '{9'h041, 9'h042, 9'h143};
    logic [8:0] got, e;
    bit wrote, acc;
    int n = 0, first = -1, last = -1;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(c < 3, words[c % 3], 1'b1, wrote, acc, got);
      if (acc) begin
        nvec++;
        if (exp_q.size() == 0) begin nfail++; $display("FAIL basic_spurious got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (e[8]) exp_pkt++;
          if (got !== e) begin nfail++; $display("FAIL basic_data got=%h exp=%h", got, e); end
        end
        if (n == 0) first = c;
        last = c;
        n++;
      end
    end
    nvec += 5;
    if (n != 3) begin nfail++; $display("FAIL basic_count got=%0d exp=3", n); end
    if (first != 3) begin nfail++; $display("FAIL basic_latency got=%0d exp=3", first); end
    if (last - first != 2) begin nfail++; $display("FAIL basic_consecutive got=%0d exp=2", last - first); end
    if (pkt_count !== 8'd1) begin nfail++; $display("FAIL basic_pkt got=%0d exp=1", pkt_count); end
    if (empty !== 1'b1) begin nfail++; $display("FAIL basic_empty got=%b exp=1", empty); end
  endtask

  task automatic test_backpressure();
    logic [8:0] got, e, start;
    bit wrote, acc;
    int n = 0;
    start = rd_ptr;
    for (int c = 0; c < 4; c++) drive_cycle(1'b1, 9'($urandom), 1'b0, wrote, acc, got);
    for (int c = 0; c < 10; c++) begin
      drive_cycle(1'b0, 9'h0, 1'b0, wrote, acc, got);
      nvec++;
      if (out_valid !== 1'b1 || got !== exp_q[0]) begin
        nfail++; $display("FAIL bp_hold valid=%b got=%h exp=%h", out_valid, got, exp_q[0]);
      end
    end
    nvec++;
    if (9'(rd_ptr - start) !== 9'd2) begin nfail++; $display("FAIL bp_rd_adv got=%0d exp=2", 9'(rd_ptr - start)); end
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b0, 9'h0, 1'b1, wrote, acc, got);
      if (acc) begin
        nvec++;
        n++;
        if (exp_q.size() == 0) begin nfail++; $display("FAIL bp_spurious got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (e[8]) exp_pkt++;
          if (got !== e) begin nfail++; $display("FAIL bp_data got=%h exp=%h", got, e); end
        end
      end
    end
    nvec += 2;
    if (n != 4) begin nfail++; $display("FAIL bp_count got=%0d exp=4", n); end
    if (pkt_count !== 8'(exp_pkt % 256)) begin nfail++; $display("FAIL bp_pkt got=%0d exp=%0d", pkt_count, exp_pkt % 256); end
  endtask

  task automatic test_wrap();
    logic [8:0] got, e;
    bit wrote, acc;
    int n = 0;
    @(negedge clk);
    wr_en = 1'b0; out_ready = 1'b1; wr_load = 1'b1; wr_load_val = 9'd510;
    @(negedge clk);
    wr_load = 1'b0; flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    nvec += 2;
    if (rd_ptr !== 9'd510) begin nfail++; $display("FAIL wrap_start got=%0d exp=510", rd_ptr); end
    if (empty !== 1'b1) begin nfail++; $display("FAIL wrap_start_empty got=%b exp=1", empty); end
    for (int c = 0; c < 20; c++) begin
      drive_cycle(c < 4, 9'($urandom), 1'b1, wrote, acc, got);
      if (acc) begin
        nvec++;
        n++;
        if (exp_q.size() == 0) begin nfail++; $display("FAIL wrap_spurious got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (e[8]) exp_pkt++;
          if (got !== e) begin nfail++; $display("FAIL wrap_data got=%h exp=%h", got, e); end
        end
      end
    end
    nvec += 4;
    if (n != 4) begin nfail++; $display("FAIL wrap_count got=%0d exp=4", n); end
    if (rd_ptr !== 9'd2) begin nfail++; $display("FAIL wrap_rd_ptr got=%0d exp=2", rd_ptr); end
    if (rd_addr !== 9'd2) begin nfail++; $display("FAIL wrap_rd_addr got=%0d exp=2", rd_addr); end
    if (empty !== 1'b1) begin nfail++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  // Flush with words both held and unread, with a simultaneous accept attempt on
  // EOP words so a wrongly counted accept would show in pkt_count.
  task automatic test_flush();
    logic [8:0] got, e;
    bit wrote, acc;
    int n;
    for (int sc = 0; sc < 2; sc++) begin
      for (int c = 0; c < 8; c++) begin
        drive_cycle(1'b1, {1'b1, 8'($urandom)}, sc == 1, wrote, acc, got);
        if (acc) begin
          nvec++;
          e = exp_q.pop_front();
          if (e[8]) exp_pkt++;
          if (got !== e) begin nfail++; $display("FAIL flush_pre_data got=%h exp=%h", got, e); end
        end
      end
      if (sc == 0) begin
        nvec++;
        if (out_valid !== 1'b1) begin nfail++; $display("FAIL flush_pre_valid got=%b exp=1", out_valid); end
      end
      @(negedge clk);
      wr_en = 1'b0; out_ready = 1'b1; flush = 1'b1;
      exp_q.delete();
      @(negedge clk);
      flush = 1'b0;
      nvec += 4;
      if (out_valid !== 1'b0) begin nfail++; $display("FAIL flush_valid sc=%0d got=%b exp=0", sc, out_valid); end
      if (rd_ptr !== wr_ptr) begin nfail++; $display("FAIL flush_ptr sc=%0d got=%0d exp=%0d", sc, rd_ptr, wr_ptr); end
      if (empty !== 1'b1) begin nfail++; $display("FAIL flush_empty sc=%0d got=%b exp=1", sc, empty); end
      if (pkt_count !== 8'(exp_pkt % 256)) begin nfail++; $display("FAIL flush_pkt sc=%0d got=%0d exp=%0d", sc, pkt_count, exp_pkt % 256); end
      for (int c = 0; c < 8; c++) begin
        drive_cycle(1'b0, 9'h0, 1'b1, wrote, acc, got);
        nvec++;
        if (out_valid !== 1'b0) begin nfail++; $display("FAIL flush_stale sc=%0d got=%h exp=none", sc, got); end
      end
    end
    n = 0;
    for (int c = 0; c < 15; c++) begin
      drive_cycle(c < 3, 9'($urandom), 1'b1, wrote, acc, got);
      if (acc) begin
        nvec++;
        n++;
        if (exp_q.size() == 0) begin nfail++; $display("FAIL flush_post_spurious got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (e[8]) exp_pkt++;
          if (got !== e) begin nfail++; $display("FAIL flush_post_data got=%h exp=%h", got, e); end
        end
      end
    end
    nvec++;
    if (n != 3) begin nfail++; $display("FAIL flush_post_count got=%0d exp=3", n); end
  endtask

  task automatic test_stress();
    logic [8:0] got, e, held_word;
    bit wrote, acc, was_held;
    bit we, rdy;
    int written = 0, taken = 0, cyc = 0;
    was_held = 1'b0;
    held_word = '0;
    while (taken < 10000 && cyc < 60000) begin
      we  = (written < 10000) && ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 70);
      drive_cycle(we, {($urandom_range(0, 9) == 0), 8'($urandom)}, rdy, wrote, acc, got);
      if (wrote) written++;
      if (was_held) begin
        nvec++;
        if (out_valid !== 1'b1 || got !== held_word) begin
          nfail++; $display("FAIL stress_stable valid=%b got=%h exp=%h", out_valid, got, held_word);
        end
      end
      was_held  = (out_valid === 1'b1) && !rdy;
      held_word = got;
      if (acc) begin
        nvec++;
        taken++;
        if (exp_q.size() == 0) begin nfail++; $display("FAIL stress_spurious got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (e[8]) exp_pkt++;
          if (got !== e) begin nfail++; $display("FAIL stress_data n=%0d got=%h exp=%h", taken, got, e); end
        end
      end
      cyc++;
    end
    nvec += 3;
    if (taken != 10000) begin nfail++; $display("FAIL stress_count got=%0d exp=10000", taken); end
    if (exp_q.size() != 0) begin nfail++; $display("FAIL stress_leftover got=%0d exp=0", exp_q.size()); end
    if (pkt_count !== 8'(exp_pkt % 256)) begin nfail++; $display("FAIL stress_pkt got=%0d exp=%0d", pkt_count, exp_pkt % 256); end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got, e;
    bit wrote, acc;
    int n = 0;
    for (int c = 0; c < 6; c++) drive_cycle(1'b1, {1'b1, 8'($urandom)}, c == 4, wrote, acc, got);
    #2;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    #1;
    nvec += 4;
    if (out_valid !== 1'b0) begin nfail++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    if (rd_ptr !== 9'd0) begin nfail++; $display("FAIL rstmid_rd_ptr got=%0d exp=0", rd_ptr); end
    if (empty !== 1'b1) begin nfail++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    if (pkt_count !== 8'd0) begin nfail++; $display("FAIL rstmid_pkt got=%0d exp=0", pkt_count); end
    exp_q.delete();
    exp_pkt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c < 2, 9'($urandom), 1'b1, wrote, acc, got);
      if (acc) begin
        nvec++;
        n++;
        if (exp_q.size() == 0) begin nfail++; $display("FAIL rstmid_spurious got=%h exp=none", got); end
        else begin
          e = exp_q.pop_front();
          if (got !== e) begin nfail++; $display("FAIL rstmid_data got=%h exp=%h", got, e); end
        end
      end
    end
    nvec++;
    if (n != 2) begin nfail++; $display("FAIL rstmid_count got=%0d exp=2", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_flush();
    test_stress();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
